data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
Memory-side responder for the core's data-memory request interface (wr_en/rd_en/size/sign_ext/addr/in_data). It replaces the zero-latency data store with a wait-stated, handshaked responder. It latches each request, optionally inserts wait states, and performs a byte, halfword or word access on an internal word array. It then returns read data (sign- or zero-extended) with a one-cycle ready pulse and an alignment-error flag. It sits between the CPU core and the top level, in place of the plain data memory.

Parameters:
DEPTH_LOG2, 10, log2 of the number of 32-bit words in the array (1024 words).
WAIT_CYCLES, 2, extra wait states inserted before each access (0..15).

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-low reset.
wr_en  input  1  write request.
rd_en  input  1  read request.
size  input  2  access size: 00 byte, 01 halfword, 10 word, 11 reserved.
sign_ext  input  1  1 = sign-extend sub-word reads, 0 = zero-extend.
addr  input  32  byte address.
in_data  input  32  write data, right-aligned; only the low size bytes are used.
out_data  output  32  read result, right-aligned and extended.
ready  output  1  one-cycle pulse: request completed.
misalign_err  output  1  qualifies ready; the request was rejected.
control_status  output  3  state code: 000 IDLE, 001 WAIT, 010 RESP_OK, 110 RESP_ERR.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; out_data=0, ready=0, misalign_err=0, control_status=000.
  - Wait counter = 0.
  - Array contents are not reset.
- IDLE, sampled at a rising edge with (rd_en|wr_en)=1:
  - Latch op, size, sign_ext, addr and in_data.
  - If the request is illegal, go to RESP_ERR and do not access the array. Illegal means any of:
    - rd_en and wr_en both high;
    - size=11;
    - size=01 with addr[0]=1;
    - size=10 with addr[1:0]!=00.
  - Otherwise go to WAIT with counter=WAIT_CYCLES.
- WAIT, at each edge:
  - If counter!=0: decrement.
  - If counter==0: perform the access and go to RESP_OK.
    - Write: update only the addressed byte lanes of word addr[DEPTH_LOG2+1:2].
    - Read: load out_data.
- Addressing:
  - Upper address bits above DEPTH_LOG2+1 are ignored (wrap-around).
  - Little-endian: byte lane addr[1:0]; halfword lane addr[1].
- Read extension:
  - Byte: bit 7 replicated to [31:8] if sign_ext=1, else zeros.
  - Halfword: bit 15 replicated to [31:16] if sign_ext=1, else zeros.
  - Word: unchanged.
- RESP_OK / RESP_ERR:
  - Held for exactly one cycle, then return to IDLE.
  - ready=1 in that cycle.
  - misalign_err=1 only in RESP_ERR.
- Latency: request sampled at edge E0; ready is high from edge E0+WAIT_CYCLES+1 to E0+WAIT_CYCLES+2.
  - WAIT_CYCLES=0 gives ready in the second cycle after the request.
  - Error responses: ready is high from E0+1 to E0+2.
- out_data rules:
  - Updated only on read completion.
  - Holds its last value through writes and IDLE.
  - Forced to 0 in RESP_ERR.
- Requests seen in WAIT or RESP are ignored.
  - Input changes during WAIT do not affect the latched request.
  - The core holds its request until ready. A request still asserted on the IDLE edge after RESP is accepted as a new request, so the core must deassert in the RESP cycle.
- Back-to-back requests: minimum spacing is WAIT_CYCLES+3 cycles (IDLE→WAIT→…→RESP→IDLE).
- Reset mid-operation:
  - An in-flight write not yet at its access edge is discarded; the array is unchanged.
  - No ready pulse is produced for the aborted request.
- ready and misalign_err are registered outputs; there is no combinational path from inputs to outputs.

Test Plan:
1. Reset values: hold rst=0 for 3 cycles, then release. Expected: out_data=0, ready=0, misalign_err=0, control_status=000, and no ready pulse while idle.
2. Word write then read, WAIT_CYCLES=2:
   - Write 0xDEADBEEF to addr 0x10. Expected: ready at E0+3 to E0+4, misalign_err=0.
   - Read word at 0x10. Expected: out_data=0xDEADBEEF at ready.
3. Sub-word reads on word 0x10 = 0xDEADBEEF:
   - Byte read addr 0x13, sign_ext=1. Expected: 0xFFFFFFDE.
   - Byte read addr 0x13, sign_ext=0. Expected: 0x000000DE.
   - Halfword read addr 0x10, sign_ext=1. Expected: 0xFFFFBEEF.
4. Byte-lane write: write byte 0x55 to addr 0x11, then read word 0x10. Expected: 0xDEAD55EF.
5. Misalignment and conflict errors. Each case expects ready+misalign_err one cycle after acceptance, out_data=0, and the array unchanged:
   - Word read addr 0x12.
   - Halfword write addr 0x11.
   - size=11.
   - rd_en=wr_en=1.
6. Reset mid-write: word write 0x12345678 to addr 0x20; pull rst low during WAIT (counter=1). Expected: no ready pulse; a later read of 0x20 returns the prior contents.
7. Wrap-around: with DEPTH_LOG2=10, write word 0xA5A5A5A5 to addr 0x1000, then read word addr 0x0. Expected: 0xA5A5A5A5.

Source files
------------

// File: rtl/data_mem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : data_mem_responder
//  Brief    : Wait-stated, handshaked data-memory responder with byte/half/word
//             access, read extension and alignment-error reporting.
//  Revision : 1.0 - initial release
// ============================================================================
module data_mem_responder #(
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] in_data,
    output logic [31:0] out_data,
    output logic        ready,
    output logic        misalign_err,
    output logic [2:0]  control_status
);

    localparam int          c_depth = 1 << DEPTH_LOG2;
    localparam int          c_aw    = DEPTH_LOG2 + 2;
    localparam logic [3:0]  c_wait  = 4'(WAIT_CYCLES);

    localparam logic [2:0]  c_st_idle     = 3'b000;
    localparam logic [2:0]  c_st_wait     = 3'b001;
    localparam logic [2:0]  c_st_resp_ok  = 3'b010;
    localparam logic [2:0]  c_st_resp_err = 3'b110;

    logic [2:0]             r_state;
    logic [3:0]             r_cnt;
    logic                   r_is_wr;
    logic                   r_err;
    logic [1:0]             r_size;
    logic                   r_sign_ext;
    logic [c_aw-1:0]        r_addr;
    logic [31:0]            r_wdata;
    logic [31:0]            r_out_data;
    logic                   r_ready;
    logic                   r_misalign_err;
    logic [31:0]            r_mem [c_depth];

    logic                   w_req;
    logic                   w_illegal;
    logic                   w_access;
    logic [DEPTH_LOG2-1:0]  w_word_idx;
    logic [3:0]             w_byte_en;
    logic [31:0]            w_wdata_lane;
    logic [31:0]            w_rd_word;
    logic [7:0]             w_rd_byte;
    logic [15:0]            w_rd_half;
    logic [31:0]            w_rd_ext;
    logic                   w_unused_addr;

    // Address bits above the array are deliberately dropped (wrap-around).
    assign w_unused_addr = ^addr[31:c_aw];

    assign w_req      = rd_en | wr_en;
    assign w_access   = (r_state == c_st_wait) && (r_cnt == 4'd0) && !r_err;
    assign w_word_idx = r_addr[c_aw-1:2];
    assign w_rd_word  = r_mem[w_word_idx];

    always_comb begin
        w_illegal = rd_en & wr_en;
        case (size)
            2'b01:   if (addr[0]) w_illegal = 1'b1;
            2'b10:   if (addr[1:0] != 2'b00) w_illegal = 1'b1;
            2'b11:   w_illegal = 1'b1;
            default: ;
        endcase
    end

    // Replicate the right-aligned write data onto every lane; byte enables pick.
    always_comb begin
        w_byte_en    = 4'b1111;
        w_wdata_lane = r_wdata;
        case (r_size)
            2'b00: begin
                w_byte_en    = 4'b0001 << r_addr[1:0];
                w_wdata_lane = {4{r_wdata[7:0]}};
            end
            2'b01: begin
                w_byte_en    = r_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata_lane = {2{r_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        case (r_addr[1:0])
            2'b00:   w_rd_byte = w_rd_word[7:0];
            2'b01:   w_rd_byte = w_rd_word[15:8];
            2'b10:   w_rd_byte = w_rd_word[23:16];
            default: w_rd_byte = w_rd_word[31:24];
        endcase
        w_rd_half = r_addr[1] ? w_rd_word[31:16] : w_rd_word[15:0];
        case (r_size)
            2'b00:   w_rd_ext = {{24{r_sign_ext & w_rd_byte[7]}}, w_rd_byte};
            2'b01:   w_rd_ext = {{16{r_sign_ext & w_rd_half[15]}}, w_rd_half};
            default: w_rd_ext = w_rd_word;
        endcase
    end

    // Illegal requests pass through one WAIT cycle with a zero count so the
    // error response arrives one cycle after acceptance, like WAIT_CYCLES=0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= c_st_idle;
            r_cnt          <= 4'd0;
            r_is_wr        <= 1'b0;
            r_err          <= 1'b0;
            r_size         <= 2'b00;
            r_sign_ext     <= 1'b0;
            r_addr         <= '0;
            r_wdata        <= 32'h0;
            r_out_data     <= 32'h0;
            r_ready        <= 1'b0;
            r_misalign_err <= 1'b0;
        end else begin
            r_ready        <= 1'b0;
            r_misalign_err <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (w_req) begin
                        r_is_wr    <= wr_en;
                        r_size     <= size;
                        r_sign_ext <= sign_ext;
                        r_addr     <= addr[c_aw-1:0];
                        r_wdata    <= in_data;
                        r_err      <= w_illegal;
                        r_cnt      <= w_illegal ? 4'd0 : c_wait;
                        r_state    <= c_st_wait;
                    end
                end
                c_st_wait: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else if (r_err) begin
                        r_state        <= c_st_resp_err;
                        r_ready        <= 1'b1;
                        r_misalign_err <= 1'b1;
                        r_out_data     <= 32'h0;
                    end else begin
                        r_state <= c_st_resp_ok;
                        r_ready <= 1'b1;
                        if (!r_is_wr) begin
                            r_out_data <= w_rd_ext;
                        end
                    end
                end
                c_st_resp_ok,
                c_st_resp_err: r_state <= c_st_idle;
                default:       r_state <= c_st_idle;
            endcase
        end
    end

    // Array contents survive reset; a reset before the access edge leaves the
    // FSM in IDLE, so an in-flight write never lands.
    always_ff @(posedge clk) begin
        if (w_access && r_is_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (w_byte_en[i]) begin
                    r_mem[w_word_idx][8*i +: 8] <= w_wdata_lane[8*i +: 8];
                end
            end
        end
    end

    assign out_data       = r_out_data;
    assign ready          = r_ready;
    assign misalign_err   = r_misalign_err;
    assign control_status = r_state;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_data_mem_responder
//  Brief    : Scoreboard bench for data_mem_responder.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

    localparam int DEPTH_LOG2  = 10;
    localparam int WAIT_CYCLES = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        sign_ext = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] in_data = 32'h0;
    logic [31:0] out_data;
    logic        ready;
    logic        misalign_err;
    logic [2:0]  control_status;

    data_mem_responder #(
        .DEPTH_LOG2  (DEPTH_LOG2),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .wr_en          (wr_en),
        .rd_en          (rd_en),
        .size           (size),
        .sign_ext       (sign_ext),
        .addr           (addr),
        .in_data        (in_data),
        .out_data       (out_data),
        .ready          (ready),
        .misalign_err   (misalign_err),
        .control_status (control_status)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model [int];
    logic [31:0] last_out = 32'h0;
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %08h expected %08h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) & ((32'h1 << DEPTH_LOG2) - 1));
    endfunction

    function automatic logic [31:0] m_word(input logic [31:0] a);
        return model.exists(widx(a)) ? model[widx(a)] : 32'h0;
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a, input logic [1:0] sz, input logic sx);
        logic [31:0] w;
        w = m_word(a);
        if (sz == 2'b00) begin
            w = (w >> (8 * a[1:0])) & 32'hFF;
            if (sx && w[7]) w = w | 32'hFFFF_FF00;
        end else if (sz == 2'b01) begin
            w = (w >> (16 * a[1])) & 32'hFFFF;
            if (sx && w[15]) w = w | 32'hFFFF_0000;
        end
        return w;
    endfunction

    task automatic m_write(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
        logic [31:0] w, mask;
        w = m_word(a);
        if (sz == 2'b00) begin
            mask = 32'hFF << (8 * a[1:0]);
            w = (w & ~mask) | ((d & 32'hFF) << (8 * a[1:0]));
        end else if (sz == 2'b01) begin
            mask = 32'hFFFF << (16 * a[1]);
            w = (w & ~mask) | ((d & 32'hFFFF) << (16 * a[1]));
        end else begin
            w = d;
        end
        model[widx(a)] = w;
    endtask

    // Every response popped here must match the oldest outstanding request.
    always @(negedge clk) begin : p_monitor
        exp_t e;
        if (rst && ready) begin
            if (sb.size() == 0) begin
                check_val("spurious_ready", 32'(ready), 32'h0);
            end else begin
                e = sb.pop_front();
                check_val("out_data", out_data, e.data);
                check_val("misalign_err", 32'(misalign_err), 32'(e.err));
                check_val("ready_cycle", 32'(cyc), 32'(e.cyc));
                check_val("status", 32'(control_status), e.err ? 32'h6 : 32'h2);
            end
        end
    end

    task automatic do_req(input logic wr, input logic rd, input logic [1:0] sz, input logic sx,
                          input logic [31:0] a, input logic [31:0] d, input bit scramble);
        exp_t e;
        bit   ill;
        int   k;
        @(negedge clk);
        ill   = (wr && rd) || (sz == 2'b11) || (sz == 2'b01 && a[0]) ||
                (sz == 2'b10 && a[1:0] != 2'b00);
        e.err = ill;
        e.cyc = cyc + 1 + (ill ? 1 : WAIT_CYCLES + 1);
        if (ill) begin
            e.data   = 32'h0;
            last_out = 32'h0;
        end else if (rd) begin
            e.data   = m_read(a, sz, sx);
            last_out = e.data;
        end else begin
            m_write(a, sz, d);
            e.data = last_out;
        end
        sb.push_back(e);
        wr_en = wr; rd_en = rd; size = sz; sign_ext = sx; addr = a; in_data = d;
        k = 0;
        if (scramble && !ill) begin
            @(negedge clk);
            k++;
            addr = $urandom; in_data = $urandom; size = 2'($urandom); sign_ext = ~sx;
        end
        while (!ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!ready) check_val("ready_timeout", 32'h0, 32'h1);
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    initial begin : p_watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin : p_stim
        logic [31:0] a;
        logic [1:0]  sz;
        int          op;

        // Reset values
        repeat (3) @(negedge clk);
        check_val("rst_out_data", out_data, 32'h0);
        check_val("rst_ready", 32'(ready), 32'h0);
        check_val("rst_misalign", 32'(misalign_err), 32'h0);
        check_val("rst_status", 32'(control_status), 32'h0);
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_val("idle_ready", 32'(ready), 32'h0);
            check_val("idle_status", 32'(control_status), 32'h0);
        end

        // Word write/read and sub-word reads
        do_req(1, 0, 2'b10, 0, 32'h10, 32'hDEAD_BEEF, 0);
        do_req(0, 1, 2'b10, 0, 32'h10, 32'h0, 0);
        do_req(0, 1, 2'b00, 1, 32'h13, 32'h0, 0);
        do_req(0, 1, 2'b00, 0, 32'h13, 32'h0, 0);
        do_req(0, 1, 2'b01, 1, 32'h10, 32'h0, 0);
        do_req(0, 1, 2'b01, 0, 32'h12, 32'h0, 1);

        // Byte-lane write (write leaves out_data holding the last read)
        do_req(1, 0, 2'b00, 0, 32'h11, 32'hFFFF_FF55, 0);
        do_req(0, 1, 2'b10, 0, 32'h10, 32'h0, 0);
        check_val("bytelane_word", out_data, 32'hDEAD_55EF);

        // Error cases; array must stay unchanged
        do_req(0, 1, 2'b10, 0, 32'h12, 32'h0, 0);
        do_req(1, 0, 2'b01, 0, 32'h11, 32'h0000_FFFF, 0);
        do_req(1, 0, 2'b11, 0, 32'h10, 32'h0, 0);
        do_req(1, 1, 2'b10, 0, 32'h10, 32'h0, 0);
        do_req(0, 1, 2'b10, 0, 32'h10, 32'h0, 0);

        // Reset during WAIT of a write
        do_req(1, 0, 2'b10, 0, 32'h20, 32'h1111_2222, 0);
        @(negedge clk);
        wr_en = 1'b1; size = 2'b10; addr = 32'h20; in_data = 32'h1234_5678;
        @(negedge clk);
        check_val("midwr_status_wait", 32'(control_status), 32'h1);
        @(negedge clk);
        rst = 1'b0;
        wr_en = 1'b0;
        #1;
        check_val("midwr_status_rst", 32'(control_status), 32'h0);
        check_val("midwr_ready", 32'(ready), 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        last_out = 32'h0;
        repeat (4) begin
            @(negedge clk);
            check_val("midwr_no_ready", 32'(ready), 32'h0);
        end
        do_req(0, 1, 2'b10, 0, 32'h20, 32'h0, 0);

        // Wrap-around
        do_req(1, 0, 2'b10, 0, 32'h1000, 32'hA5A5_A5A5, 0);
        do_req(0, 1, 2'b10, 0, 32'h0, 32'h0, 0);

        // Randomised mix over a small window
        for (int i = 0; i < 4; i++) do_req(1, 0, 2'b10, 0, 32'h40 + 32'(4 * i), $urandom, 0);
        for (int i = 0; i < 24; i++) begin
            a  = 32'h40 + 32'($urandom_range(0, 15));
            sz = 2'($urandom_range(0, 3));
            op = $urandom_range(0, 6);
            do_req(op == 0 || op >= 4, op == 0 || (op >= 1 && op <= 3), sz,
                   1'($urandom), a, $urandom, 1'($urandom));
        end

        repeat (3) @(negedge clk);
        check_val("sb_drained", 32'(sb.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
